// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline control unit for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
// Produces per-stage enables plus stall, flush and bubble control. It tracks
// the register usage of in-flight instructions in three shadow stages
// (EX, MEM, WB) that advance in lock-step with the datapath pipeline registers.
// From those shadows it derives the EX operand-forwarding selects, the
// ID-stage regfile bypass selects and the data-hazard stall.
//
// Parameters
//   REG_ADDR_W  : register address width (x0 is hardwired zero)
//   FWD_EN      : 1 = forwarding, stall only on load-use
//                 0 = stall on any RAW against EX/MEM/WB
//   STALL_CNT_W : width of the saturating data-stall cycle counter
//
// Ports
//   clk, rst                    : clock (rising edge), async active-high reset
//   ext_stall                   : memory-wait freeze request
//   branch_taken                : branch/jump in EX resolved taken
//   id_valid                    : IF/ID holds a real instruction
//   id_rs1_addr, id_rs2_addr    : ID source register addresses
//   id_rs1_used, id_rs2_used    : ID instruction reads rs1 / rs2
//   id_rd_addr, id_rd_wr_en     : ID destination register and write enable
//   id_is_load                  : ID instruction is a load
//   pc_wr_en                    : PC may advance
//   if_id_wr_en, if_id_flush    : IF/ID load enable / clear to NOP
//   id_ex_bubble                : load NOP control into ID/EX
//   pipeline_advance            : ID/EX, EX/MEM, MEM/WB load enable
//   fwd_a_sel, fwd_b_sel        : EX operand mux selects (00 reg, 01 MEM, 10 WB)
//   id_byp_rs1, id_byp_rs2      : ID read takes the WB write data
//   stall_cycles                : saturating count of data-stall cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_EN      = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_stall,
  input  logic                   branch_taken,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [REG_ADDR_W-1:0]  id_rd_addr,
  input  logic                   id_rd_wr_en,
  input  logic                   id_is_load,
  output logic                   pc_wr_en,
  output logic                   if_id_wr_en,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   pipeline_advance,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   id_byp_rs1,
  output logic                   id_byp_rs2,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Register-usage record of one in-flight instruction.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr_en;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } shadow_t;

  // Control mode of the current cycle, in priority order.
  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_STALL  = 2'd1,
    MODE_BRANCH = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_e;

  localparam int                     SHADOW_W   = $bits(shadow_t);
  localparam shadow_t                SHADOW_NOP = {SHADOW_W{1'b0}};
  localparam logic [REG_ADDR_W-1:0]  REG_ZERO   = {REG_ADDR_W{1'b0}};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX    = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE    = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  shadow_t                ex_sh;
  shadow_t                mem_sh;
  shadow_t                wb_sh;
  shadow_t                id_sh;
  shadow_t                ex_next;
  mode_e                  mode;
  logic                   ex_hit;
  logic                   mem_hit;
  logic                   wb_hit;
  logic                   data_stall;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   unused_shadow_bits;

  // A stage produces a result for addr only if it really writes a non-x0 register.
  function automatic logic writes_to(input shadow_t s, input logic [REG_ADDR_W-1:0] addr);
    writes_to = s.valid & s.wr_en & (s.rd != REG_ZERO) & (s.rd == addr);
  endfunction

  // ID instruction reads a register that stage s is going to write.
  function automatic logic id_reads_from(input shadow_t s);
    id_reads_from = (id_rs1_used & writes_to(s, id_rs1_addr)) |
                    (id_rs2_used & writes_to(s, id_rs2_addr));
  endfunction

  // Forward source for one EX operand: the younger MEM result beats WB.
  function automatic logic [1:0] fwd_select(input logic                  used,
                                            input logic [REG_ADDR_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (used && writes_to(mem_sh, src)) begin
      sel = FWD_MEM;
    end else if (used && writes_to(wb_sh, src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  // Gather the ID-stage fields into a shadow record.
  always_comb begin
    id_sh          = SHADOW_NOP;
    id_sh.valid    = id_valid;
    id_sh.rd       = id_rd_addr;
    id_sh.wr_en    = id_rd_wr_en;
    id_sh.is_load  = id_is_load;
    id_sh.rs1      = id_rs1_addr;
    id_sh.rs2      = id_rs2_addr;
    id_sh.rs1_used = id_rs1_used;
    id_sh.rs2_used = id_rs2_used;
  end

  // RAW hazard detection between ID and the in-flight stages.
  always_comb begin
    ex_hit  = id_reads_from(ex_sh);
    mem_hit = id_reads_from(mem_sh);
    wb_hit  = id_reads_from(wb_sh);
    if (FWD_EN != 0) begin
      // Only a load in EX cannot be forwarded in time.
      data_stall = id_valid & ex_hit & ex_sh.is_load;
    end else begin
      data_stall = id_valid & (ex_hit | mem_hit | wb_hit);
    end
  end

  // Resolve the control mode by priority: ext_stall > branch > data stall.
  always_comb begin
    mode = MODE_RUN;
    if (rst || ext_stall) begin
      mode = MODE_FREEZE;
    end else if (branch_taken) begin
      mode = MODE_BRANCH;
    end else if (data_stall) begin
      mode = MODE_STALL;
    end else begin
      mode = MODE_RUN;
    end
  end

  // Pipeline enables, flush/bubble and the next EX shadow for each mode.
  always_comb begin
    pc_wr_en         = 1'b0;
    if_id_wr_en      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    pipeline_advance = 1'b0;
    ex_next          = SHADOW_NOP;
    case (mode)
      MODE_RUN: begin
        pc_wr_en         = 1'b1;
        if_id_wr_en      = 1'b1;
        pipeline_advance = 1'b1;
        ex_next          = id_sh;
      end
      MODE_STALL: begin
        // Hold PC and IF/ID, push a bubble so the producer moves on.
        id_ex_bubble     = 1'b1;
        pipeline_advance = 1'b1;
      end
      MODE_BRANCH: begin
        // Wrong-path instruction in IF/ID is squashed by the flush.
        pc_wr_en         = 1'b1;
        if_id_wr_en      = 1'b1;
        if_id_flush      = 1'b1;
        id_ex_bubble     = 1'b1;
        pipeline_advance = 1'b1;
      end
      MODE_FREEZE: begin
        pipeline_advance = 1'b0;
      end
      default: begin
        pipeline_advance = 1'b0;
      end
    endcase
  end

  // Operand forwarding and ID bypass selects, forced to zero during reset.
  always_comb begin
    fwd_a_sel  = FWD_NONE;
    fwd_b_sel  = FWD_NONE;
    id_byp_rs1 = 1'b0;
    id_byp_rs2 = 1'b0;
    if (rst) begin
      fwd_a_sel  = FWD_NONE;
      fwd_b_sel  = FWD_NONE;
    end else begin
      if (FWD_EN != 0) begin
        fwd_a_sel = fwd_select(ex_sh.rs1_used, ex_sh.rs1);
        fwd_b_sel = fwd_select(ex_sh.rs2_used, ex_sh.rs2);
      end else begin
        fwd_a_sel = FWD_NONE;
        fwd_b_sel = FWD_NONE;
      end
      // Regfile writes at the same edge ID reads, so WB data must bypass.
      id_byp_rs1 = id_rs1_used & writes_to(wb_sh, id_rs1_addr);
      id_byp_rs2 = id_rs2_used & writes_to(wb_sh, id_rs2_addr);
    end
  end

  // Shadow stages advance with the datapath pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_sh  <= SHADOW_NOP;
      mem_sh <= SHADOW_NOP;
      wb_sh  <= SHADOW_NOP;
    end else if (pipeline_advance) begin
      ex_sh  <= ex_next;
      mem_sh <= ex_sh;
      wb_sh  <= mem_sh;
    end else begin
      ex_sh  <= ex_sh;
      mem_sh <= mem_sh;
      wb_sh  <= wb_sh;
    end
  end

  // Saturating count of cycles lost to data hazards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= {STALL_CNT_W{1'b0}};
    end else if ((mode == MODE_STALL) && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign stall_cycles = stall_cnt;

  // Source fields of MEM/WB only matter in EX; keep them for debug visibility.
  assign unused_shadow_bits = ^{mem_sh, wb_sh};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (forwarding, no-forwarding, and
// forwarding with a 2-bit stall counter) share one stimulus stream. A
// vector table with hand-derived expectations, directed multi-cycle
// sequences and a randomized phase are checked; every cycle also compares
// all instances against an instruction-level reference model.
module tb_hazard_ctrl;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
  } instr_t;

  typedef struct {
    bit       pc;
    bit       ifid;
    bit       fl;
    bit       bub;
    bit       adv;
    bit [1:0] fa;
    bit [1:0] fb;
    bit       b1;
    bit       b2;
  } outs_t;

  typedef struct {
    bit     ext;
    bit     br;
    instr_t id;
    outs_t  exp;
    int     sc;
  } vec_t;

  logic clk = 1'b0;
  logic rst, ext_stall, branch_taken;
  instr_t cur_id;
  logic id_valid, id_rs1_used, id_rs2_used, id_rd_wr_en, id_is_load;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;

  logic pc_o [3];
  logic ifid_o [3];
  logic fl_o [3];
  logic bub_o [3];
  logic adv_o [3];
  logic [1:0] fa_o [3];
  logic [1:0] fb_o [3];
  logic b1_o [3];
  logic b2_o [3];
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: stage 0 = EX, 1 = MEM, 2 = WB
  instr_t st [3][3];
  int     cnt [3];

  assign id_valid    = cur_id.v;
  assign id_rd_addr  = cur_id.rd;
  assign id_rd_wr_en = cur_id.wr;
  assign id_is_load  = cur_id.ld;
  assign id_rs1_addr = cur_id.rs1;
  assign id_rs2_addr = cur_id.rs2;
  assign id_rs1_used = cur_id.u1;
  assign id_rs2_used = cur_id.u2;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .STALL_CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .branch_taken(branch_taken),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
    .id_rd_wr_en(id_rd_wr_en), .id_is_load(id_is_load),
    .pc_wr_en(pc_o[0]), .if_id_wr_en(ifid_o[0]), .if_id_flush(fl_o[0]),
    .id_ex_bubble(bub_o[0]), .pipeline_advance(adv_o[0]), .fwd_a_sel(fa_o[0]),
    .fwd_b_sel(fb_o[0]), .id_byp_rs1(b1_o[0]), .id_byp_rs2(b2_o[0]), .stall_cycles(sc0));

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(0), .STALL_CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .branch_taken(branch_taken),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
    .id_rd_wr_en(id_rd_wr_en), .id_is_load(id_is_load),
    .pc_wr_en(pc_o[1]), .if_id_wr_en(ifid_o[1]), .if_id_flush(fl_o[1]),
    .id_ex_bubble(bub_o[1]), .pipeline_advance(adv_o[1]), .fwd_a_sel(fa_o[1]),
    .fwd_b_sel(fb_o[1]), .id_byp_rs1(b1_o[1]), .id_byp_rs2(b2_o[1]), .stall_cycles(sc1));

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .STALL_CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .branch_taken(branch_taken),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
    .id_rd_wr_en(id_rd_wr_en), .id_is_load(id_is_load),
    .pc_wr_en(pc_o[2]), .if_id_wr_en(ifid_o[2]), .if_id_flush(fl_o[2]),
    .id_ex_bubble(bub_o[2]), .pipeline_advance(adv_o[2]), .fwd_a_sel(fa_o[2]),
    .fwd_b_sel(fb_o[2]), .id_byp_rs1(b1_o[2]), .id_byp_rs2(b2_o[2]), .stall_cycles(sc2));

  function automatic instr_t mk(bit v, int rd, bit wr, bit ld, int rs1, int rs2, bit u1, bit u2);
    instr_t i;
    i.v = v; i.rd = 5'(rd); i.wr = wr; i.ld = ld;
    i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = u1; i.u2 = u2;
    return i;
  endfunction

  function automatic outs_t o(bit pc, bit ifid, bit fl, bit bub, bit adv, int fa, int fb, bit b1, bit b2);
    outs_t r;
    r.pc = pc; r.ifid = ifid; r.fl = fl; r.bub = bub; r.adv = adv;
    r.fa = 2'(fa); r.fb = 2'(fb); r.b1 = b1; r.b2 = b2;
    return r;
  endfunction

  function automatic vec_t row(bit ext, bit br, instr_t id, outs_t exp, int sc);
    vec_t r;
    r.ext = ext; r.br = br; r.id = id; r.exp = exp; r.sc = sc;
    return r;
  endfunction

  function automatic int pk(outs_t r);
    return int'({r.pc, r.ifid, r.fl, r.bub, r.adv, r.fa, r.fb, r.b1, r.b2});
  endfunction

  function automatic outs_t got(int m);
    outs_t g;
    g.pc = pc_o[m]; g.ifid = ifid_o[m]; g.fl = fl_o[m]; g.bub = bub_o[m];
    g.adv = adv_o[m]; g.fa = fa_o[m]; g.fb = fb_o[m]; g.b1 = b1_o[m]; g.b2 = b2_o[m];
    return g;
  endfunction

  function automatic int sc_act(int m);
    case (m)
      1:       return int'(sc1);
      2:       return int'(sc2);
      default: return int'(sc0);
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic bit writes(instr_t s, bit [4:0] a);
    return s.v && s.wr && (s.rd != 5'd0) && (s.rd == a);
  endfunction

  function automatic bit depends(instr_t rdr, instr_t s);
    return (rdr.u1 && writes(s, rdr.rs1)) || (rdr.u2 && writes(s, rdr.rs2));
  endfunction

  function automatic bit m_stall(int m);
    if (!cur_id.v) return 1'b0;
    if (m != 1) return depends(cur_id, st[m][0]) && st[m][0].ld;
    for (int k = 0; k < 3; k++) if (depends(cur_id, st[m][k])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [1:0] m_fwd(int m, bit used, bit [4:0] a);
    if (m == 1 || !used) return 2'd0;
    if (writes(st[m][1], a)) return 2'd1;
    if (writes(st[m][2], a)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic outs_t model_out(int m);
    outs_t e;
    e = o(0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (rst) return e;
    if (ext_stall) e = o(0, 0, 0, 0, 0, 0, 0, 0, 0);
    else if (branch_taken) e = o(1, 1, 1, 1, 1, 0, 0, 0, 0);
    else if (m_stall(m)) e = o(0, 0, 0, 1, 1, 0, 0, 0, 0);
    else e = o(1, 1, 0, 0, 1, 0, 0, 0, 0);
    e.fa = m_fwd(m, st[m][0].u1, st[m][0].rs1);
    e.fb = m_fwd(m, st[m][0].u2, st[m][0].rs2);
    e.b1 = cur_id.u1 && writes(st[m][2], cur_id.rs1);
    e.b2 = cur_id.u2 && writes(st[m][2], cur_id.rs2);
    return e;
  endfunction

  task automatic model_update();
    instr_t nop;
    bit s;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) st[m][k] = nop;
        cnt[m] = 0;
      end else if (!ext_stall) begin
        s = m_stall(m);
        st[m][2] = st[m][1];
        st[m][1] = st[m][0];
        st[m][0] = (branch_taken || s) ? nop : cur_id;
        if (!branch_taken && s && cnt[m] < ((m == 2) ? 3 : 65535)) cnt[m]++;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic cmp(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    outs_t e, g;
    for (int m = 0; m < 3; m++) begin
      e = model_out(m);
      g = got(m);
      // IF/ID load enable during a flush is not significant
      if (!rst && !ext_stall && branch_taken) g.ifid = e.ifid;
      cmp($sformatf("model_u%0d_ctl", m), pk(g), pk(e));
      cmp($sformatf("model_u%0d_stall_cycles", m), sc_act(m), rst ? 0 : cnt[m]);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic edge_adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(bit r, bit e, bit b, instr_t i);
    rst = r; ext_stall = e; branch_taken = b; cur_id = i;
  endtask

  task automatic cyc(bit e, bit b, instr_t i);
    drive(1'b0, e, b, i);
    sample();
    edge_adv();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    sample();
    edge_adv();
  endtask

  vec_t vt [18];
  instr_t nop_i, add_sub, ld7, use7;
  outs_t g0;

  initial begin
    nop_i = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vt[0]  = row(0, 0, mk(1, 5, 1, 0, 1, 2, 1, 1),    o(1, 1, 0, 0, 1, 0, 0, 0, 0), 0);
    vt[1]  = row(0, 0, mk(1, 6, 1, 0, 5, 5, 1, 1),    o(1, 1, 0, 0, 1, 0, 0, 0, 0), 0);
    vt[2]  = row(0, 0, mk(1, 9, 1, 0, 5, 0, 1, 1),    o(1, 1, 0, 0, 1, 1, 1, 0, 0), 0);
    vt[3]  = row(0, 0, mk(1, 7, 1, 1, 2, 0, 1, 0),    o(1, 1, 0, 0, 1, 2, 0, 0, 0), 0);
    vt[4]  = row(0, 0, mk(1, 8, 1, 0, 7, 0, 1, 1),    o(0, 0, 0, 1, 1, 0, 0, 0, 0), 0);
    vt[5]  = row(0, 0, mk(1, 8, 1, 0, 7, 0, 1, 1),    o(1, 1, 0, 0, 1, 0, 0, 0, 0), 1);
    vt[6]  = row(0, 0, nop_i,                         o(1, 1, 0, 0, 1, 2, 0, 0, 0), 1);
    vt[7]  = row(0, 0, mk(1, 0, 1, 1, 1, 0, 1, 0),    o(1, 1, 0, 0, 1, 0, 0, 0, 0), 1);
    vt[8]  = row(0, 0, mk(1, 10, 1, 0, 0, 0, 1, 1),   o(1, 1, 0, 0, 1, 0, 0, 0, 0), 1);
    vt[9]  = row(0, 0, mk(1, 11, 1, 0, 10, 0, 1, 1),  o(1, 1, 0, 0, 1, 0, 0, 0, 0), 1);
    vt[10] = row(0, 0, mk(1, 12, 1, 0, 0, 10, 1, 1),  o(1, 1, 0, 0, 1, 1, 0, 0, 0), 1);
    vt[11] = row(0, 0, mk(1, 13, 1, 0, 10, 11, 1, 1), o(1, 1, 0, 0, 1, 0, 2, 1, 0), 1);
    vt[12] = row(0, 0, mk(1, 14, 1, 1, 1, 0, 1, 0),   o(1, 1, 0, 0, 1, 0, 2, 0, 0), 1);
    vt[13] = row(0, 1, mk(1, 15, 1, 0, 14, 0, 1, 1),  o(1, 1, 1, 1, 1, 0, 0, 0, 0), 1);
    vt[14] = row(0, 0, mk(1, 15, 1, 0, 14, 0, 1, 1),  o(1, 1, 0, 0, 1, 0, 0, 0, 0), 1);
    vt[15] = row(1, 1, mk(1, 16, 1, 0, 15, 0, 1, 1),  o(0, 0, 0, 0, 0, 2, 0, 0, 0), 1);
    vt[16] = row(1, 1, mk(1, 16, 1, 0, 15, 0, 1, 1),  o(0, 0, 0, 0, 0, 2, 0, 0, 0), 1);
    vt[17] = row(0, 1, mk(1, 16, 1, 0, 15, 0, 1, 1),  o(1, 1, 1, 1, 1, 2, 0, 0, 0), 1);

    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 3; k++) st[m][k] = nop_i;
      cnt[m] = 0;
    end

    // reset state
    do_reset();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, nop_i);
    @(negedge clk);
    cmp("reset_ctl_u0", pk(got(0)), 0);
    cmp("reset_stall_cycles_u0", sc_act(0), 0);
    edge_adv();

    // vector table, hand-derived expectations for the forwarding instance
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, vt[i].ext, vt[i].br, vt[i].id);
      sample();
      g0 = got(0);
      if (vt[i].br && !vt[i].ext) g0.ifid = vt[i].exp.ifid;
      cmp($sformatf("vec%0d_ctl", i), pk(g0), pk(vt[i].exp));
      cmp($sformatf("vec%0d_stall_cycles", i), sc_act(0), vt[i].sc);
      edge_adv();
    end

    // ext_stall held over a branch and a load-use, then release
    ld7  = mk(1, 7, 1, 1, 1, 0, 1, 0);
    use7 = mk(1, 8, 1, 0, 7, 0, 1, 1);
    cyc(1'b0, 1'b0, ld7);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, use7);
      sample();
      cmp($sformatf("ext%0d_enables", i), {pc_o[0], ifid_o[0], adv_o[0], fl_o[0], bub_o[0]}, 0);
      cmp($sformatf("ext%0d_stall_cycles", i), sc_act(0), 1);
      edge_adv();
    end
    drive(1'b0, 1'b0, 1'b1, use7);
    sample();
    cmp("ext_release_branch", {pc_o[0], fl_o[0], bub_o[0], adv_o[0]}, 4'hf);
    edge_adv();
    drive(1'b0, 1'b0, 1'b0, use7);
    sample();
    cmp("ext_release_no_stall", pc_o[0], 1);
    cmp("branch_keeps_stall_cycles", sc_act(0), 1);
    edge_adv();

    // reset mid-run with a writer of x5 in EX
    cyc(1'b0, 1'b0, mk(1, 5, 1, 0, 1, 2, 1, 1));
    drive(1'b1, 1'b0, 1'b0, mk(1, 6, 1, 0, 5, 5, 1, 1));
    #1;
    for (int m = 0; m < 3; m++) begin
      cmp($sformatf("midrst_ctl_u%0d", m), pk(got(m)), 0);
      cmp($sformatf("midrst_stall_cycles_u%0d", m), sc_act(m), 0);
    end
    sample();
    edge_adv();
    drive(1'b0, 1'b0, 1'b0, nop_i);
    sample();
    cmp("post_rst_fwd", {fa_o[0], fb_o[0]}, 0);
    cmp("post_rst_stall_cycles", sc_act(0), 0);
    edge_adv();

    // no-forwarding instance: add x3 ; sub x4,x3,x1 costs 3 stalls
    do_reset();
    cyc(1'b0, 1'b0, mk(1, 3, 1, 0, 1, 2, 1, 1));
    add_sub = mk(1, 4, 1, 0, 3, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, add_sub);
      sample();
      cmp($sformatf("nofwd_pc%0d", i), pc_o[1], (i == 3) ? 1 : 0);
      cmp($sformatf("nofwd_byp%0d", i), b1_o[1], (i == 2) ? 1 : 0);
      cmp($sformatf("fwd_no_stall%0d", i), pc_o[0], 1);
      edge_adv();
    end
    cmp("nofwd_stall_cycles", sc_act(1), 3);

    // five load-use pairs: 16-bit counter reaches 5, 2-bit counter saturates
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, ld7);
      cyc(1'b0, 1'b0, use7);
      cyc(1'b0, 1'b0, use7);
    end
    cmp("sat_u0_stall_cycles", sc_act(0), 5);
    cmp("sat_u2_stall_cycles", sc_act(2), 3);

    // randomized phase against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            mk($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1));
      sample();
      edge_adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
